// File: rtl/mag_pkg.sv
// Shared constants and FSM state type for the magnitude request scheduler.
// Optional build macro (see mag_req_scheduler.sv): MAG_ROUND_EN.
package mag_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int DW_DEFAULT   = 8;
  localparam int ID_W         = (NREQ_DEFAULT > 1) ? $clog2(NREQ_DEFAULT) : 1;
  localparam int SUM_W        = 2 * DW_DEFAULT + 1;
  localparam int RES_W        = DW_DEFAULT + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROOT  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Width of an ID field for n requesters (at least one bit).
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/isqrt_iter.sv
// Restoring digit-by-digit integer square root, one result bit per cycle.
// start loads the radicand and clears root/remainder; the engine then runs
// DW+1 iterations (counter DW down to 0). done_o is high during the final
// iteration, so root_o/rem_o are final from the following cycle and hold
// until the next start. ena low freezes every register.
module isqrt_iter #(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start_i,
  input  logic [2*DW:0]     sum_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DW:0]       root_o,
  output logic [DW+1:0]     rem_o
);

  localparam int SUM_W = 2 * DW + 1;
  localparam int RES_W = DW + 1;
  localparam int REM_W = RES_W + 1;
  localparam int PAD_W = 2 * RES_W;
  localparam int CNT_W = $clog2(DW + 1);

  logic [PAD_W-1:0] sum_q;
  logic [REM_W-1:0] rem_q;
  logic [RES_W-1:0] root_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic [REM_W+1:0] rem_t;
  logic [REM_W+1:0] trial;
  logic [REM_W+1:0] rem_sub;
  logic             take;
  logic [REM_W-1:0] rem_d;
  logic [RES_W-1:0] root_d;

  // One restoring step: bring down the next bit pair and try subtracting 4r+1.
  always_comb begin
    rem_t   = {rem_q, sum_q[PAD_W-1 -: 2]};
    trial   = {1'b0, root_q, 2'b01};
    take    = (rem_t >= trial);
    rem_sub = rem_t - trial;
    rem_d   = take ? rem_sub[REM_W-1:0] : rem_t[REM_W-1:0];
    root_d  = {root_q[RES_W-2:0], take};
  end

  // Engine registers: load on start, iterate while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (ena) begin
      if (start_i) begin
        sum_q  <= {{(PAD_W-SUM_W){1'b0}}, sum_i};
        rem_q  <= '0;
        root_q <= '0;
        cnt_q  <= CNT_W'(DW);
        run_q  <= 1'b1;
      end else if (run_q) begin
        sum_q  <= {sum_q[PAD_W-3:0], 2'b00};
        rem_q  <= rem_d;
        root_q <= root_d;
        if (cnt_q == '0) begin
          run_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign busy_o = run_q;
  assign done_o = run_q && (cnt_q == '0);
  assign root_o = root_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/mag_req_scheduler.sv
// Round-robin scheduler sharing one iterative magnitude engine,
// floor(sqrt(x^2+y^2)), among NREQ requesters.
// Optional build macro MAG_ROUND_EN: adds a ROUND state that rounds the
// root to nearest (r+1 when sum - r^2 > r); latency grows by one cycle.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge with ena high. req_ready is a one-hot combinational
// grant, only in IDLE and only for an asserted req_valid; req_valid is never
// latched and may drop without a transfer. res_valid is held in DONE with
// res_mag/res_id stable until res_ready is seen with ena high.
module mag_req_scheduler
  import mag_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int DW   = DW_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*DW-1:0]            req_x,
  input  logic [NREQ*DW-1:0]            req_y,
  output logic [NREQ-1:0]               req_ready,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DW:0]                   res_mag,
  output logic [id_width(NREQ)-1:0]     res_id,
  output logic                          busy,
  output logic [2:0]                    dbg_state
);

  localparam int IW = id_width(NREQ);
  localparam int SW = 2 * DW + 1;
  localparam int RW = DW + 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q;
  logic [DW-1:0]   x_q, y_q;

  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  logic            start;
  logic            eng_busy;
  logic            eng_done;
  logic [RW-1:0]   root_w;
  logic [RW:0]     rem_w;
  logic [SW-1:0]   xx, yy, sum_w;
  int              idx;

  // Round-robin search: first asserted request at or above the pointer, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    if (int'(gnt_idx) == NREQ - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx + 1'b1;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena && gnt_any) begin
          req_ready[gnt_idx] = 1'b1;
          state_d            = LOAD;
        end
      end
      LOAD: begin
        if (ena) begin
          start   = 1'b1;
          state_d = ROOT;
        end
      end
      ROOT: begin
        if (ena && eng_done) begin
`ifdef MAG_ROUND_EN
          state_d = ROUND;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MAG_ROUND_EN
      ROUND: begin
        if (ena) state_d = DONE;
      end
`endif
      DONE: begin
        if (ena && res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else if (ena) state_q <= state_d;
  end

  // Operand/ID capture and pointer advance on a granted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      id_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (ena && state_q == IDLE && gnt_any) begin
      ptr_q <= ptr_d;
      id_q  <= gnt_idx;
      x_q   <= req_x[int'(gnt_idx)*DW +: DW];
      y_q   <= req_y[int'(gnt_idx)*DW +: DW];
    end
  end

  assign xx    = SW'(x_q);
  assign yy    = SW'(y_q);
  assign sum_w = xx * xx + yy * yy;

  isqrt_iter #(.DW(DW)) u_isqrt (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start_i (start),
    .sum_i   (sum_w),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .root_o  (root_w),
    .rem_o   (rem_w)
  );

`ifdef MAG_ROUND_EN
  logic [RW-1:0] mag_q;

  // Round to nearest: the remainder sum - r^2 exceeding r means sqrt > r + 0.5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mag_q <= '0;
    else if (ena && state_q == ROUND) mag_q <= (rem_w > {1'b0, root_w}) ? root_w + 1'b1 : root_w;
  end

  assign res_mag = mag_q;
`else
  logic unused_rem;
  assign unused_rem = ^rem_w;
  assign res_mag    = root_w;
`endif

  assign res_valid = (state_q == DONE);
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE) || eng_busy;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mag_req_scheduler.sv
// Directed bench for mag_req_scheduler (NREQ=4, DW=8).
module tb_mag_req_scheduler;

`ifdef MAG_ROUND_EN
  localparam int LAT   = 12;
  localparam int E_MAX = 361;
  localparam int E_23  = 4;
`else
  localparam int LAT   = 11;
  localparam int E_MAX = 360;
  localparam int E_23  = 3;
`endif

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req_valid;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [8:0]  res_mag;
  logic [1:0]  res_id;
  logic        busy;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mag_req_scheduler #(.NREQ(4), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_mag   (res_mag),
    .res_id    (res_id),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset helper: assert for three cycles, release on a falling edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Driver: issue one request from requester rid at a falling edge in IDLE,
  // optionally stall ena for stall_len cycles at cycle stall_at, and return
  // the grant seen, the cycle count to res_valid and the result fields.
  task automatic run_op(input int rid, input logic [7:0] x, input logic [7:0] y,
                        input int stall_at, input int stall_len,
                        output int lat, output logic [8:0] mag,
                        output logic [1:0] id, output logic [3:0] gnt);
    req_x[rid*8 +: 8] = x;
    req_y[rid*8 +: 8] = y;
    req_valid = 4'b0001 << rid;
    #1;
    gnt = req_ready;
    @(negedge clk);
    req_valid = 4'b0000;
    lat = 1;
    while (res_valid !== 1'b1 && lat < 60) begin
      if (stall_len > 0 && lat == stall_at) begin
        ena = 1'b0;
        repeat (stall_len) @(negedge clk);
        lat += stall_len;
        ena = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    mag = res_mag;
    id  = res_id;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (res_mag !== 9'd0 || res_id !== 2'd0) begin errors++; $display("FAIL reset_result got mag %0d id %0d want 0 0", res_mag, res_id); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int lat; logic [8:0] mag; logic [1:0] id; logic [3:0] gnt;
    res_ready = 1'b1;
    run_op(0, 8'd3, 8'd4, 0, 0, lat, mag, id, gnt);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_grant got %b want 0001", gnt); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    checks++; if (mag !== 9'd5 || id !== 2'd0) begin errors++; $display("FAIL basic_3_4 got mag %0d id %0d want 5 0", mag, id); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", res_valid); end
    run_op(3, 8'd255, 8'd255, 0, 0, lat, mag, id, gnt);
    checks++; if (mag !== 9'(E_MAX) || id !== 2'd3) begin errors++; $display("FAIL basic_max got mag %0d id %0d want %0d 3", mag, id, E_MAX); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL basic_max_latency got %0d want %0d", lat, LAT); end
    run_op(1, 8'd2, 8'd3, 0, 0, lat, mag, id, gnt);
    checks++; if (mag !== 9'(E_23) || id !== 2'd1) begin errors++; $display("FAIL basic_2_3 got mag %0d id %0d want %0d 1", mag, id, E_23); end
    run_op(2, 8'd0, 8'd0, 0, 0, lat, mag, id, gnt);
    checks++; if (mag !== 9'd0 || id !== 2'd2) begin errors++; $display("FAIL basic_zero got mag %0d id %0d want 0 2", mag, id); end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp_mag [4];
    logic       bad_hot;
    int         w;
    int         cyc;
    int         r;
    exp_mag[0] = 9'd5; exp_mag[1] = 9'd10; exp_mag[2] = 9'd13; exp_mag[3] = 9'd17;
    apply_reset();
    req_x = {8'd8, 8'd5, 8'd6, 8'd3};
    req_y = {8'd15, 8'd12, 8'd8, 8'd4};
    req_valid = 4'hf;
    res_ready = 1'b1;
    bad_hot = 1'b0;
    for (int g = 0; g < 5; g++) begin
      r = g % 4;
      #1;
      w = 0;
      while (req_ready === 4'b0 && w < 10) begin
        @(negedge clk); #1; w++;
      end
      checks++; if (req_ready !== (4'b0001 << r)) begin errors++; $display("FAIL rr_grant_%0d got %b want %b", g, req_ready, 4'b0001 << r); end
      @(negedge clk);
      cyc = 1;
      while (res_valid !== 1'b1 && cyc < 40) begin
        if (!$onehot0(req_ready) || req_ready !== 4'b0) bad_hot = 1'b1;
        @(negedge clk);
        cyc++;
      end
      checks++; if (res_mag !== exp_mag[r] || res_id !== 2'(r)) begin errors++; $display("FAIL rr_result_%0d got mag %0d id %0d want %0d %0d", g, res_mag, res_id, exp_mag[r], r); end
      if (g == 4) req_valid = 4'h0;
      @(negedge clk);
    end
    checks++; if (bad_hot !== 1'b0) begin errors++; $display("FAIL rr_ready_outside_idle got %b want 0", bad_hot); end
  endtask

  task automatic test_backpressure();
    int   cyc;
    logic bad_valid, bad_mag, bad_id, bad_rdy;
    res_ready = 1'b0;
    req_x[2*8 +: 8] = 8'd6;
    req_y[2*8 +: 8] = 8'd8;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'hf;
    cyc = 1;
    bad_rdy = 1'b0;
    while (res_valid !== 1'b1 && cyc < 40) begin
      if (req_ready !== 4'b0) bad_rdy = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checks++; if (res_mag !== 9'd10 || res_id !== 2'd2) begin errors++; $display("FAIL bp_result got mag %0d id %0d want 10 2", res_mag, res_id); end
    bad_valid = 1'b0; bad_mag = 1'b0; bad_id = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1) bad_valid = 1'b1;
      if (res_mag !== 9'd10) bad_mag = 1'b1;
      if (res_id !== 2'd2) bad_id = 1'b1;
      if (req_ready !== 4'b0) bad_rdy = 1'b1;
    end
    checks++; if (bad_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_held got drop %b want 0", bad_valid); end
    checks++; if (bad_mag !== 1'b0 || bad_id !== 1'b0) begin errors++; $display("FAIL bp_result_stable got mag_chg %b id_chg %b want 0 0", bad_mag, bad_id); end
    checks++; if (bad_rdy !== 1'b0) begin errors++; $display("FAIL bp_no_ready got pulse %b want 0", bad_rdy); end
    req_valid = 4'h0;
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_release got res_valid %b want 0", res_valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_single_consume got busy %b want 0", busy); end
  endtask

  task automatic test_ena();
    int lat; logic [8:0] mag; logic [1:0] id; logic [3:0] gnt;
    logic bad;
    res_ready = 1'b1;
    ena = 1'b0;
    req_x[7:0] = 8'd3;
    req_y[7:0] = 8'd4;
    req_valid = 4'b0001;
    bad = 1'b0;
    repeat (3) begin
      #1;
      if (req_ready !== 4'b0 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL ena_idle_no_grant got %b want 0", bad); end
    req_valid = 4'h0;
    ena = 1'b1;
    @(negedge clk);
    run_op(1, 8'd255, 8'd255, 4, 5, lat, mag, id, gnt);
    checks++; if (lat != LAT + 5) begin errors++; $display("FAIL ena_stall_latency got %0d want %0d", lat, LAT + 5); end
    checks++; if (mag !== 9'(E_MAX) || id !== 2'd1) begin errors++; $display("FAIL ena_stall_result got mag %0d id %0d want %0d 1", mag, id, E_MAX); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [8:0] mag; logic [1:0] id; logic [3:0] gnt;
    logic stale;
    res_ready = 1'b1;
    req_x[3*8 +: 8] = 8'd255;
    req_y[3*8 +: 8] = 8'd255;
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = 4'h0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got valid %b ready %b busy %b want 0", res_valid, req_ready, busy); end
    checks++; if (res_mag !== 9'd0 || res_id !== 2'd0) begin errors++; $display("FAIL rstmid_result got mag %0d id %0d want 0 0", res_mag, res_id); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rstmid_stale got %b want 0", stale); end
    run_op(0, 8'd6, 8'd8, 0, 0, lat, mag, id, gnt);
    checks++; if (mag !== 9'd10 || id !== 2'd0 || lat != LAT) begin errors++; $display("FAIL rstmid_next got mag %0d id %0d lat %0d want 10 0 %0d", mag, id, lat, LAT); end
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    req_valid = 4'h0;
    req_x     = '0;
    req_y     = '0;
    res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_ena();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mag_req_scheduler.md
Name: mag_req_scheduler

Overview:
- Shares one iterative magnitude engine, computing floor(sqrt(x^2+y^2)), among NREQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Sequences square-and-sum, then one bit per cycle of square root.
- Returns the result tagged with the requester ID on a valid/ready result port.
- Sits between the ui_in/uio_in sample logic and the uo_out driver of the magnitude datapath.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- DW, 8: operand width. Sum width is 2*DW+1. Result width is DW+1; max floor result for DW=8 is 360.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  global enable; low freezes all state.
- req_valid  in  NREQ  per-requester operand valid.
- req_x  in  NREQ*DW  packed x operands; requester i occupies bits [i*DW +: DW].
- req_y  in  NREQ*DW  packed y operands, same packing.
- req_ready  out  NREQ  one-hot grant/accept strobe.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_mag  out  DW+1  magnitude result.
- res_id  out  clog2(NREQ)  ID of the requester that owns the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer 0, engine registers 0.
- FSM states and transitions:
  - IDLE: if any req_valid, grant the first asserted requester scanning from the pointer upward with wrap. The granted req_ready is high combinationally in this cycle; capture x, y and the ID; pointer <= granted+1 mod NREQ; go to LOAD. If no req_valid, stay in IDLE with req_ready all 0.
  - LOAD (1 cycle): sum <= x*x + y*y (2*DW+1 bits, no overflow); clear root and remainder; go to ROOT.
  - ROOT (DW+1 cycles): restoring digit-by-digit square root, one result bit per cycle, MSB first; iteration counter counts DW down to 0. After the last iteration go to DONE (or ROUND if the feature is enabled).
  - DONE: res_valid=1; res_mag and res_id hold stable. On res_valid & res_ready go to IDLE; res_valid drops the next cycle.
- Latency: handshake cycle = 0, LOAD = 1, ROOT = 2..DW+2, res_valid first high in cycle DW+3 (11 for DW=8).
- Throughput: at most one outstanding operation. req_ready is never asserted outside IDLE, so a new grant occurs at the earliest in the cycle after the result handshake.
- req_ready is never high for a requester whose req_valid is low, and is never multi-hot.
- Requester-side rule: req_valid may drop without a handshake. It is not sticky; the scheduler never latches it.
- ena=0: FSM, counters, pointer and registers hold; req_ready forced to 0; res_valid holds its value; a result handshake is ignored while ena=0.
- Reset mid-operation aborts the computation; no result is emitted afterwards.
- Simultaneous requests are granted strictly in round-robin order. A lone requester can be granted back-to-back.
- Zero operands return 0. Max operands 255,255 return 360.

Optional Feature:
- MAG_ROUND_EN defined: adds a 1-cycle ROUND state between ROOT and DONE. res_mag <= r+1 if (sum - r^2) > r, else r, where r is the floor root; this is round-to-nearest. Latency becomes DW+4; the result still fits DW+1 bits (max 361).
- Undefined: no ROUND state; the result is floor.

Decomposition:
- Package mag_pkg holds:
  - DW and NREQ defaults;
  - the ID-width constant;
  - the FSM state enum {IDLE, LOAD, ROOT, ROUND, DONE};
  - SUM_W = 2*DW+1 and RES_W = DW+1.
- Sub-module isqrt_iter: start/busy/done handshake and the restoring iterative root. It owns the sum, remainder, root and counter. The top keeps the arbiter, operand capture, FSM and result port.

Test Plan:
- Requester 0 sends x=3, y=4; res_ready=1 → res_mag=5, res_id=0, res_valid high exactly 11 cycles after the handshake.
- x=255, y=255 → 360; with MAG_ROUND_EN → 361 at 12 cycles. x=2, y=3 → 3; with rounding → 4. x=0, y=0 → 0.
- All 4 req_valid held high with distinct operands → grants in order 0,1,2,3,0; each result tagged with the matching res_id; req_ready always one-hot.
- res_ready=0 for 20 cycles after res_valid → res_valid, res_mag and res_id stable; no req_ready pulses; exactly one result is consumed on release.
- ena=0 for 5 cycles mid-ROOT → result correct and delayed by exactly 5 cycles. ena=0 in IDLE with req_valid=1 → no grant.
- rst_n asserted mid-ROOT → all outputs 0 immediately; after release no stale result; the next request (x=6, y=8) → 10.
